// File: rtl/stage_ctrl_pkg.sv
// rtl/stage_ctrl_pkg.sv - shared state type, default parameters and widths for stage_ctrl
package stage_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_BOSS = 3'd2,
    ST_WIN  = 3'd3,
    ST_LOSE = 3'd4
  } state_t;

  localparam int DEF_HITS_PER_STAGE = 8;
  localparam int DEF_BOSS_STAGE     = 3;
  localparam int DEF_BOSS_HITS      = 16;
  localparam int DEF_MAX_MISS       = 3;

  // Stage number width (boss output)
  localparam int STAGE_W = 5;
  // Internal event counter width; wide enough for any 8-bit threshold
  localparam int CNT_W   = 8;

  // Score increment that sticks at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/stage_ctrl_hit_counter.sv
// rtl/stage_ctrl_hit_counter.sv - clearable saturating event counter with terminal-count flag
module hit_counter
  import stage_ctrl_pkg::*;
#(
  parameter int W    = CNT_W,
  parameter int TERM = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic last
);

  logic [W-1:0] count;

  // Clear wins over increment; increments stop at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // High when the next counted event reaches TERM, so the owner can act in that same cycle
  assign last = (count == W'(TERM - 1));

endmodule

// File: rtl/stage_ctrl.sv
// rtl/stage_ctrl.sv - game stage controller: normal stages, boss stage, win/lose tracking
module stage_ctrl
  import stage_ctrl_pkg::*;
#(
  parameter int HITS_PER_STAGE = DEF_HITS_PER_STAGE,
  parameter int BOSS_STAGE     = DEF_BOSS_STAGE,
  parameter int BOSS_HITS      = DEF_BOSS_HITS,
  parameter int MAX_MISS       = DEF_MAX_MISS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               hit,
  input  logic               miss,
  input  logic               pause,
  output logic [STAGE_W-1:0] boss,
  output logic               start,
  output logic [7:0]         score,
  output logic               win,
  output logic               lose
);

  state_t             state;
  logic [1:0]         arm;
  logic               in_run;
  logic               in_boss;
  logic               playing;
  logic               start_game;
  logic               eff_miss;
  logic               armed;
  logic               stage_last;
  logic               boss_last;
  logic               miss_last;
  logic               stage_wrap;
  logic               enter_boss;
  logic [STAGE_W-1:0] boss_nx;

  assign in_run     = (state == ST_RUN);
  assign in_boss    = (state == ST_BOSS);
  assign playing    = in_run | in_boss;
  assign start_game = go & ~playing;
  // A miss arriving together with a hit is dropped
  assign eff_miss   = miss & ~hit;
  // Pause only counts once two BOSS cycles have elapsed (timer start-up latency)
  assign armed      = (arm == 2'd2);
  assign stage_wrap = in_run & hit & stage_last;
  assign boss_nx    = (boss == '1) ? boss : boss + 1'b1;
  assign enter_boss = stage_wrap & (boss_nx == STAGE_W'(BOSS_STAGE));

  hit_counter #(.W(CNT_W), .TERM(HITS_PER_STAGE)) u_stage_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_game | stage_wrap),
    .inc  (in_run & hit),
    .last (stage_last)
  );

  hit_counter #(.W(CNT_W), .TERM(BOSS_HITS)) u_boss_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_game | enter_boss),
    .inc  (in_boss & hit),
    .last (boss_last)
  );

  hit_counter #(.W(CNT_W), .TERM(MAX_MISS)) u_miss_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_game),
    .inc  (playing & eff_miss),
    .last (miss_last)
  );

  // Game FSM with all outputs registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      arm   <= 2'd0;
      boss  <= '0;
      start <= 1'b0;
      score <= 8'd0;
      win   <= 1'b0;
      lose  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (go) begin
            state <= ST_RUN;
            arm   <= 2'd0;
            boss  <= STAGE_W'(1);
            start <= 1'b1;
            score <= 8'd0;
            win   <= 1'b0;
            lose  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (hit) begin
            score <= sat_inc8(score);
          end
          if (stage_wrap) begin
            boss <= boss_nx;
            if (enter_boss) begin
              state <= ST_BOSS;
              arm   <= 2'd0;
            end
          end else if (eff_miss && miss_last) begin
            state <= ST_LOSE;
            start <= 1'b0;
            lose  <= 1'b1;
          end
        end
        ST_BOSS: begin
          if (!armed) begin
            arm <= arm + 2'd1;
          end
          if (hit) begin
            score <= sat_inc8(score);
          end
          if (hit && boss_last) begin
            state <= ST_WIN;
            start <= 1'b0;
            win   <= 1'b1;
          end else if ((eff_miss && miss_last) || (pause && armed)) begin
            state <= ST_LOSE;
            start <= 1'b0;
            lose  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          boss  <= '0;
          start <= 1'b0;
          win   <= 1'b0;
          lose  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_ctrl.sv
// tb/tb_stage_ctrl.sv - self-checking bench for stage_ctrl
module tb_stage_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go = 1'b0, hit = 1'b0, miss = 1'b0, pause = 1'b0;
  logic [4:0] boss, boss2;
  logic [7:0] score, score2;
  logic start, start2, win, win2, lose, lose2;

  stage_ctrl dut (
    .clk(clk), .rst(rst), .go(go), .hit(hit), .miss(miss), .pause(pause),
    .boss(boss), .start(start), .score(score), .win(win), .lose(lose)
  );

  stage_ctrl #(.HITS_PER_STAGE(255), .BOSS_STAGE(31)) dut_big (
    .clk(clk), .rst(rst), .go(go), .hit(hit), .miss(miss), .pause(pause),
    .boss(boss2), .start(start2), .score(score2), .win(win2), .lose(lose2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model of the default-parameter game
  localparam int HPS = 8, BST = 3, BHITS = 16, MM = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_BOSS = 2, M_WIN = 3, M_LOSE = 4;
  int m_st, m_boss, m_stage_hits, m_boss_hits, m_misses, m_score, m_boss_cycles;

  task automatic model_reset();
    m_st = M_IDLE; m_boss = 0; m_stage_hits = 0; m_boss_hits = 0;
    m_misses = 0; m_score = 0; m_boss_cycles = 0;
  endtask

  task automatic model_step(input logic g, input logic h, input logic m, input logic p);
    bit pause_live;
    if (m_st == M_IDLE || m_st == M_WIN || m_st == M_LOSE) begin
      if (g) begin
        m_st = M_RUN; m_boss = 1; m_stage_hits = 0; m_misses = 0; m_score = 0;
      end
    end else if (m_st == M_RUN) begin
      if (h) begin
        m_score = (m_score < 255) ? m_score + 1 : 255;
        m_stage_hits++;
        if (m_stage_hits == HPS) begin
          m_stage_hits = 0;
          m_boss = (m_boss < 31) ? m_boss + 1 : 31;
          if (m_boss == BST) begin
            m_st = M_BOSS; m_boss_hits = 0; m_boss_cycles = 0;
          end
        end
      end else if (m) begin
        m_misses++;
        if (m_misses == MM) m_st = M_LOSE;
      end
    end else begin
      pause_live = (m_boss_cycles >= 2);
      m_boss_cycles++;
      if (h) begin
        m_score = (m_score < 255) ? m_score + 1 : 255;
        m_boss_hits++;
        if (m_boss_hits == BHITS) m_st = M_WIN;
        else if (p && pause_live) m_st = M_LOSE;
      end else begin
        if (m) m_misses++;
        if (m_misses == MM || (p && pause_live)) m_st = M_LOSE;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".boss"},  int'(boss),  m_boss);
    check({tag, ".start"}, int'(start), (m_st == M_RUN || m_st == M_BOSS) ? 1 : 0);
    check({tag, ".score"}, int'(score), m_score);
    check({tag, ".win"},   int'(win),   (m_st == M_WIN) ? 1 : 0);
    check({tag, ".lose"},  int'(lose),  (m_st == M_LOSE) ? 1 : 0);
  endtask

  task automatic check_out(input string tag, input int b, input int s, input int sc,
                           input int w, input int l);
    check({tag, ".boss"},  int'(boss),  b);
    check({tag, ".start"}, int'(start), s);
    check({tag, ".score"}, int'(score), sc);
    check({tag, ".win"},   int'(win),   w);
    check({tag, ".lose"},  int'(lose),  l);
  endtask

  // One clock with the given inputs held across the edge, sampled 1 ns after it
  task automatic tick(input logic g, input logic h, input logic m, input logic p);
    go = g; hit = h; miss = m; pause = p;
    @(posedge clk);
    #1;
    model_step(g, h, m, p);
    go = 1'b0; hit = 1'b0; miss = 1'b0; pause = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic g, h, m, p;
    int   boss, start, score, win, lose;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic g, input logic h, input logic m, input logic p,
                              input int b, input int s, input int sc, input int w, input int l);
    vec_t v;
    v.g = g; v.h = h; v.m = m; v.p = p;
    v.boss = b; v.start = s; v.score = sc; v.win = w; v.lose = l;
    return v;
  endfunction

  initial begin
    // go, 16 hits through two stages, then pause held across the arming window
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    for (int k = 1; k <= 16; k++) vecs.push_back(mk(0, 1, 0, 0, 1 + k / 8, 1, k, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 1, 16, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 1, 16, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 16, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1, 3, 0, 16, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 1, 0, 0));

    do_reset();
    check_out("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].g, vecs[i].h, vecs[i].m, vecs[i].p);
      check_out($sformatf("vec%0d", i), vecs[i].boss, vecs[i].start, vecs[i].score,
                vecs[i].win, vecs[i].lose);
    end

    // Boss defeated on a hit that coincides with pause
    do_reset();
    tick(1, 0, 0, 0);
    for (int k = 0; k < 16; k++) tick(0, 1, 0, 0);
    for (int k = 0; k < 15; k++) tick(0, 1, 0, 0);
    check_out("boss15", 3, 1, 31, 0, 0);
    tick(0, 1, 0, 1);
    check_out("boss_win", 3, 0, 32, 1, 0);
    tick(1, 0, 0, 0);
    check_out("win_restart", 1, 1, 0, 0, 0);

    // Miss counting with a discarded miss
    do_reset();
    tick(1, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 1, 1, 0);
    tick(0, 0, 1, 0);
    check_out("miss3", 1, 1, 1, 0, 0);
    tick(0, 0, 1, 0);
    check_out("miss4", 1, 0, 1, 0, 1);

    // Asynchronous reset in the middle of a boss fight
    do_reset();
    tick(1, 0, 0, 0);
    for (int k = 0; k < 16; k++) tick(0, 1, 0, 0);
    tick(0, 1, 0, 0);
    check_out("pre_arst", 3, 1, 17, 0, 0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_out("arst", 0, 0, 0, 0, 0);
    #1;
    rst = 1'b0;
    tick(0, 1, 1, 1);
    check_out("idle_ignore", 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0);
    check_out("arst_go", 1, 1, 0, 0, 0);

    // Score saturation on the wide-stage instance
    do_reset();
    tick(1, 0, 0, 0);
    for (int k = 1; k <= 300; k++) begin
      tick(0, 1, 0, 0);
      if (k == 254) check("sat254.score", int'(score2), 254);
      if (k == 255) begin
        check("sat255.score", int'(score2), 255);
        check("sat255.boss", int'(boss2), 2);
      end
    end
    check("sat300.score", int'(score2), 255);
    check("sat300.boss", int'(boss2), 2);
    check("sat300.start", int'(start2), 1);

    // Random play against the reference model
    do_reset();
    check_model("rnd_reset");
    for (int c = 0; c < 3000; c++) begin
      tick(($urandom % 30) == 0, ($urandom % 2) == 0, ($urandom % 16) == 0, ($urandom % 4) == 0);
      check_model($sformatf("rnd%0d", c));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
